// File: rtl/fifo_pkg.sv
// Shared types and defaults for the flow-controlled FIFO: default widths, depth helper,
// pause FSM states and the packed status-flag bundle.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } pause_state_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
    logic almost_empty;
    logic pause;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_fc_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, no reset.
// Zero read latency; no backpressure, the caller gates we.
module fifo_fc_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_fc_param.sv
// Parametrised sync FIFO with programmable thresholds, hysteretic pause and sticky errors; 1-cycle read,
// or 0-cycle first-word-fall-through when FIFO_FWFT_EN is defined. Pause throttles upstream; overflows are dropped.
module fifo_fc_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              pause,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(fifo_depth(ADDR_W));
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;
  pause_state_t      state_q, state_d;
  fifo_flags_t       flags;
  logic              push_acc, pop_acc;
  logic [DATA_W-1:0] rdata;

  assign pop_acc  = pop & ~flags.empty;
  assign push_acc = push & (~flags.full | pop_acc);

  fifo_fc_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc & reset),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    wr_ptr_d  = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d  = pop_acc  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d   = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Set wins over clear when a new error lands in the clearing cycle.
    err_ovf_d = (push & ~push_acc) | (err_ovf_q & ~err_clr);
    err_udf_d = (pop & ~pop_acc)   | (err_udf_q & ~err_clr);
  end

  // Pause FSM: with af <= ae the release test is always true below af, so no hysteresis.
  always_comb begin
    state_d = state_q;
    if (count_d >= af_thresh) begin
      state_d = PAUSED;
    end else if (count_d <= ae_thresh) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
      state_q   <= RUN;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    flags              = '0;
    flags.empty        = (count_q == '0);
    flags.full         = (count_q == DEPTH_CNT);
    flags.almost_full  = (count_q >= af_thresh);
    flags.almost_empty = (count_q <= ae_thresh) && (count_q != '0);
    flags.pause        = (state_q == PAUSED);
  end

`ifdef FIFO_FWFT_EN
  assign data_out   = rdata;
  assign data_valid = ~flags.empty;
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;

  always_comb begin
    data_out_d   = pop_acc ? rdata : data_out_q;
    data_valid_d = pop_acc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`endif

  assign count         = count_q;
  assign empty         = flags.empty;
  assign full          = flags.full;
  assign almost_full   = flags.almost_full;
  assign almost_empty  = flags.almost_empty;
  assign pause         = flags.pause;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_udf_q;

endmodule

// File: tb/tb_fifo_fc_param.sv
// Directed bench for fifo_fc_param with a queue scoreboard and a reference model of count/flags/pause.
// Works in both read modes; define FIFO_FWFT_EN for the zero-latency variant.
module tb_fifo_fc_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              push, pop, err_clr;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W:0]   af_thresh, ae_thresh;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [ADDR_W:0]   count;
  logic              empty, full, almost_full, almost_empty, pause;
  logic              err_overflow, err_underflow;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         m_count;
  logic       m_pause, m_ovf, m_udf;
  logic [7:0] last_out;

  fifo_fc_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .pop           (pop),
    .data_in       (data_in),
    .af_thresh     (af_thresh),
    .ae_thresh     (ae_thresh),
    .err_clr       (err_clr),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .pause         (pause),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), 32'(m_count));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("full", 32'(full), 32'(m_count == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(m_count >= int'(af_thresh)));
    chk("almost_empty", 32'(almost_empty), 32'(m_count <= int'(ae_thresh) && m_count != 0));
    chk("pause", 32'(pause), 32'(m_pause));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_underflow", 32'(err_underflow), 32'(m_udf));
  endtask

  // One clock of stimulus: inputs applied 1ns after a rising edge, results checked 1ns after the next.
  task automatic cycle(input logic p, input logic q, input logic [7:0] d, input logic c);
    logic       pa, wa;
    logic [7:0] got;
    int         nxt;
    got = 8'h00;
    push = p; pop = q; data_in = d; err_clr = c;
    pa = q && (m_count != 0);
    wa = p && (m_count != DEPTH || pa);
`ifdef FIFO_FWFT_EN
    #1;
    chk("fwft_valid", 32'(data_valid), 32'(m_count != 0));
    if (m_count != 0) chk("fwft_head", 32'(data_out), 32'(exp_q[0]));
`endif
    if (pa) got = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    nxt = m_count + (wa ? 1 : 0) - (pa ? 1 : 0);
    m_ovf = (p && !wa) || (m_ovf && !c);
    m_udf = (q && !pa) || (m_udf && !c);
    if (af_thresh > ae_thresh) begin
      if (nxt >= int'(af_thresh)) m_pause = 1'b1;
      else if (nxt <= int'(ae_thresh)) m_pause = 1'b0;
    end else begin
      m_pause = (nxt >= int'(af_thresh));
    end
    m_count = nxt;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
`ifndef FIFO_FWFT_EN
    chk("data_valid", 32'(data_valid), 32'(pa));
    if (pa) begin
      chk("data_out", 32'(data_out), 32'(got));
      last_out = got;
    end else begin
      chk("data_hold", 32'(data_out), 32'(last_out));
    end
`endif
    check_state();
  endtask

  task automatic do_reset(input logic p);
    reset = 1'b0; push = p; pop = 1'b0; data_in = 8'h5A; err_clr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; push = 1'b0;
    exp_q.delete();
    m_count = 0; m_pause = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; last_out = 8'h00;
    chk("rst_valid", 32'(data_valid), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("rst_data", 32'(data_out), 32'd0);
`endif
    check_state();
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; data_in = '0;
    af_thresh = 4'd6; ae_thresh = 4'd2;
    m_count = 0; m_pause = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; last_out = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // Fill to full; pause asserts as count reaches 6.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h11 + i), 1'b0);
    // Overflow at full, then drain in order.
    cycle(1'b1, 1'b0, 8'h19, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Hysteresis: 6 -> pause, 3 holds, 2 releases, 5 stays released.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);

    // Top up to full, then simultaneous push/pop long enough to wrap pointers.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Underflow, push+pop on empty, set-over-clear, then clear.
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'hC1, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);

    // Thresholds without hysteresis (af <= ae), changed while idle.
    af_thresh = 4'd2; ae_thresh = 4'd5;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    af_thresh = 4'd6; ae_thresh = 4'd2;

    // Reset mid-stream with a push in the same cycle.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
    do_reset(1'b1);
    cycle(1'b1, 1'b0, 8'h81, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_fc_param.md
Name: fifo_fc_param

Overview:
- Parametrised synchronous FIFO with flow control, for ingress/egress buffering between the PCIe switch lanes and the arbitration logic.
- Generalises the 8-bit, fixed-threshold FIFO. Data width and depth are parameters.
- Almost-full and almost-empty thresholds are run-time programmable.
- Pause uses hysteresis. Overflow and underflow error flags are sticky and separate, and there is an explicit occupancy count.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- push  in  1  write request.
- pop  in  1  read request.
- data_in  in  DATA_W  write data.
- af_thresh  in  ADDR_W+1  almost-full / pause-assert threshold.
- ae_thresh  in  ADDR_W+1  almost-empty / pause-release threshold.
- err_clr  in  1  clears sticky error flags.
- data_out  out  DATA_W  read data.
- data_valid  out  1  data_out holds a newly popped word.
- count  out  ADDR_W+1  occupancy, range 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- almost_full  out  1  count>=af_thresh.
- almost_empty  out  1  count<=ae_thresh and count!=0.
- pause  out  1  back-pressure to the upstream source.
- err_overflow  out  1  sticky: push rejected.
- err_underflow  out  1  sticky: pop rejected.

Behaviour:
- Reset (reset==0 at clk edge): wr_ptr, rd_ptr and count go to 0. data_out=0, data_valid=0, pause=0, err_overflow=0, err_underflow=0. Therefore empty=1 and full, almost_full, almost_empty are 0. Memory contents are not cleared.
- Reset mid-operation: reset has priority over push/pop in the same cycle. In-flight data is discarded.
- pop_acc = pop & !empty.
- push_acc = push & (!full | pop_acc). Push is accepted at full when a pop is accepted in the same cycle.
- Simultaneous push and pop when empty: push is accepted, pop is rejected, err_underflow is set. Count goes 0->1.
- Count update: +1 on push_acc only, -1 on pop_acc only, unchanged on both or neither. Count never leaves 0..DEPTH.
- Pointers: ADDR_W bits wide, increment on accept, wrap naturally DEPTH-1 -> 0.
- Status flags are combinational from the registered count. They reflect an operation on the cycle after its edge.
- Read latency is 1 cycle. On pop_acc, data_out <= mem[rd_ptr] and data_valid <= 1. Otherwise data_valid <= 0 and data_out holds its value.
- Rejected push (push & !push_acc): data is dropped, pointers are unchanged, err_overflow <= 1.
- Rejected pop (pop & !pop_acc): err_underflow <= 1, data_out holds, data_valid <= 0.
- err_clr clears both error flags next cycle. If a new error occurs in the same cycle, set wins over clear.
- Pause, when af_thresh > ae_thresh: pause <= 1 when next-count >= af_thresh; pause <= 0 when next-count <= ae_thresh; otherwise it holds. This gives hysteresis.
- Pause, when af_thresh <= ae_thresh: pause <= (next-count >= af_thresh), i.e. no hysteresis.
- Thresholds are sampled every cycle. Software changes them only while the FIFO is idle.

Optional Feature:
FIFO_FWFT_EN:
- Defined: first-word-fall-through mode. data_out = mem[rd_ptr] combinationally, data_valid = !empty, and pop_acc advances rd_ptr. Read latency is 0, and data_out is undefined when empty.
- Not defined: the registered 1-cycle read path described above.

Decomposition:
- Package fifo_pkg: default DATA_W/ADDR_W localparams, a depth function (2**ADDR_W), and a typedef for the flag bundle {empty, full, almost_full, almost_empty, pause}.
- Sub-module fifo_fc_mem: DEPTH x DATA_W storage with synchronous write (we, waddr, wdata) and asynchronous read (raddr, rdata).
- The top level holds the pointers, count, flags, the read register and the pause FSM (states RUN/PAUSED).

Test Plan (DATA_W=8, ADDR_W=3, af_thresh=6, ae_thresh=2):
- Reset, then push 0x11..0x18 on 8 consecutive cycles -> count=8, full=1; almost_full=1 from count=6; pause rises on the edge where count reaches 6.
- From full, 9th push with pop=0 -> err_overflow=1, count stays 8, 0x19 dropped. Then pop 8x -> data_out 0x11..0x18 in order, each 1 cycle after its pop, with data_valid pulsing.
- Pause hysteresis: fill to 6 (pause=1), pop to 3 -> pause stays 1; pop to 2 -> pause=0; push to 5 -> pause stays 0.
- At full, push 0xAA and pop together -> both accepted, count stays 8, no error. Repeat 20 cycles so pointers wrap -> output sequence preserved.
- On empty, pop alone -> err_underflow=1, data_valid=0. Push+pop together -> count=1, err_underflow stays 1. err_clr -> both error flags 0.
- Mid-stream (count=4) drive reset=0 with push=1 -> count=0, empty=1, pause=0, data_valid=0.
- Repeat all scenarios with FIFO_FWFT_EN defined -> data_out equals the head word with 0 latency.
